serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/FA.sv | 19 +
 rtl/serial_adder.sv | 138 +++++++++++++
 tb/tb_serial_adder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: FSM state encoding and the
//   default operand width. Imported by serial_adder and its testbench.
package serial_adder_pkg;

    // Encodings are fixed so that waveforms and other blocks can decode them.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/FA.sv
// FA
//   Single-bit full adder, purely combinational.
//   Ports:
//     a, b  : addend bits
//     cin   : carry in
//     s     : sum bit
//     cout  : carry out
module FA (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: computes a + b + cin one bit per clock, LSB first,
//   through a single full-adder slice. The result is published to sum/cout
//   only when the last bit has been processed.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     start  : begin an addition (honoured only in IDLE or DONE)
//     a, b   : operands, sampled on an accepted start
//     cin    : carry-in, sampled on an accepted start
//     busy   : high while bits are being shifted (SHIFT state)
//     done   : one-cycle pulse when sum/cout have just been updated
//     sum    : registered result, WIDTH bits
//     cout   : registered carry-out
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // One extra bit so the counter can represent WIDTH without wrapping.
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               slice_s;
    logic               slice_cout;
    logic [WIDTH-1:0]   psum_next;

    FA u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at
    // position 0 and the register holds the complete result.
    assign psum_next = WIDTH'({slice_s, psum_q} >> 1);

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        psum_d  = psum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    psum_d  = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // start is deliberately not looked at here.
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = slice_cout;
                psum_d  = psum_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    sum_d   = psum_next;
                    cout_d  = slice_cout;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags follow the next state so they are registered with it.
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            psum_q  <= psum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Scoreboard bench for serial_adder. Two instances: WIDTH=8 for directed,
//   random, restart, reset and back-to-back operation, and WIDTH=4 for an
//   exhaustive sweep. Expected results come from plain integer addition.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int checks = 0;
    int passes = 0;

    logic [8:0] exp8_q[$];
    logic [4:0] exp4_q[$];
    logic [8:0] held8 = '0;
    logic [4:0] held4 = '0;
    logic [8:0] e8;
    logic [4:0] e4;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    // Reference model: full-precision addition, carry-out is the top bit.
    function automatic logic [8:0] refAdd8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int full;
        full = int'(x) + int'(y) + int'(c);
        return 9'(full);
    endfunction

    function automatic logic [4:0] refAdd4(input logic [3:0] x, input logic [3:0] y, input logic c);
        int full;
        full = int'(x) + int'(y) + int'(c);
        return 5'(full);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor for the 8-bit instance: pops on every done, otherwise the
    // outputs must hold the last published result.
    always @(negedge clk) begin
        if (!rst_n) begin
            held8 = '0;
        end else if (done8) begin
            if (exp8_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL result8: done with no outstanding request at %0t", $time);
            end else begin
                e8 = exp8_q.pop_front();
                checkOutput("result8", 32'({cout8, sum8}), 32'(e8));
                held8 = e8;
            end
        end else begin
            checkOutput("hold8", 32'({cout8, sum8}), 32'(held8));
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            held4 = '0;
        end else if (done4) begin
            if (exp4_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL result4: done with no outstanding request at %0t", $time);
            end else begin
                e4 = exp4_q.pop_front();
                checkOutput("result4", 32'({cout4, sum4}), 32'(e4));
                held4 = e4;
            end
        end else begin
            checkOutput("hold4", 32'({cout4, sum4}), 32'(held4));
        end
    end

    // Called at the first falling edge after acceptance (lat = 1). Optionally
    // pulses start with fresh operands mid-operation, which must be ignored.
    task automatic waitDone8(input int injectAt, output int lat, output int busyCnt);
        lat = 1;
        busyCnt = 0;
        while (!done8 && lat < 40) begin
            if (busy8) busyCnt++;
            if (injectAt != 0 && lat == injectAt) begin
                start8 = 1'b1;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                cin8 = 1'b1;
            end
            if (injectAt != 0 && lat == injectAt + 1) start8 = 1'b0;
            @(negedge clk);
            lat++;
        end
        checkOutput("done8 seen", 32'(done8), 32'd1);
    endtask

    task automatic waitDone4(output int lat);
        lat = 1;
        while (!done4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("done4 seen", 32'(done4), 32'd1);
    endtask

    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic c, input int injectAt);
        int lat;
        int bc;
        @(negedge clk);
        a8 = x;
        b8 = y;
        cin8 = c;
        start8 = 1'b1;
        exp8_q.push_back(refAdd8(x, y, c));
        @(negedge clk);
        start8 = 1'b0;
        waitDone8(injectAt, lat, bc);
        checkOutput("latency8", 32'(lat), 32'd9);
        checkOutput("busy8 length", 32'(bc), 32'd8);
    endtask

    // start held high across n operations; operands for the next one are
    // changed during the current SHIFT and must not disturb it.
    task automatic holdStart8(input int n);
        int lat;
        int bc;
        logic [7:0] x, y;
        logic c;
        @(negedge clk);
        x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
        a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
        exp8_q.push_back(refAdd8(x, y, c));
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k < n - 1) begin
                x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
                a8 = x; b8 = y; cin8 = c;
                exp8_q.push_back(refAdd8(x, y, c));
            end else begin
                start8 = 1'b0;
            end
            waitDone8(0, lat, bc);
            checkOutput("period8", 32'(lat), 32'd9);
        end
    endtask

    task automatic sweep4();
        int lat;
        logic [8:0] iv;
        @(negedge clk);
        a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0; start4 = 1'b1;
        exp4_q.push_back(refAdd4(4'd0, 4'd0, 1'b0));
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (i < 511) begin
                iv = 9'(i + 1);
                a4 = iv[3:0]; b4 = iv[7:4]; cin4 = iv[8];
                exp4_q.push_back(refAdd4(iv[3:0], iv[7:4], iv[8]));
            end else begin
                start4 = 1'b0;
            end
            waitDone4(lat);
            checkOutput("period4", 32'(lat), 32'd5);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global timeout at %0t", $time);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy8", 32'(busy8), 32'd0);
        checkOutput("reset done8", 32'(done8), 32'd0);
        checkOutput("reset sum8", 32'({cout8, sum8}), 32'd0);
        checkOutput("reset busy4", 32'(busy4), 32'd0);
        checkOutput("reset sum4", 32'({cout4, sum4}), 32'd0);
        #2 rst_n = 1'b1;

        $display("[TB] directed cases");
        applyStimulus(8'hFF, 8'h01, 1'b0, 0);
        checkOutput("ff+01", 32'({cout8, sum8}), 32'h100);
        applyStimulus(8'h55, 8'hAA, 1'b1, 0);
        checkOutput("55+aa+1", 32'({cout8, sum8}), 32'h100);
        applyStimulus(8'h12, 8'h34, 1'b0, 0);
        checkOutput("12+34", 32'({cout8, sum8}), 32'h046);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 0);
        checkOutput("ff+ff+1", 32'({cout8, sum8}), 32'h1FF);

        $display("[TB] start ignored during shift");
        applyStimulus(8'h21, 8'h13, 1'b0, 3);
        checkOutput("restart ignored", 32'({cout8, sum8}), 32'h034);

        $display("[TB] random operations");
        for (int i = 0; i < 25; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), (i % 3 == 0) ? 2 + (i % 5) : 0);
        end

        $display("[TB] reset during shift");
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b1; start8 = 1'b1;
        exp8_q.push_back(refAdd8(8'h5A, 8'h3C, 1'b1));
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("busy before abort", 32'(busy8), 32'd1);
        #2 rst_n = 1'b0;
        exp8_q.delete();
        #1;
        checkOutput("abort busy8", 32'(busy8), 32'd0);
        checkOutput("abort done8", 32'(done8), 32'd0);
        checkOutput("abort sum8", 32'({cout8, sum8}), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(8'h03, 8'h04, 1'b0, 0);
        checkOutput("03+04 after reset", 32'({cout8, sum8}), 32'h007);

        $display("[TB] start held high");
        holdStart8(3);
        holdStart8(4);

        $display("[TB] exhaustive WIDTH=4");
        sweep4();

        repeat (4) @(negedge clk);
        checkOutput("pending8", 32'(exp8_q.size()), 32'd0);
        checkOutput("pending4", 32'(exp4_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
